// File: rtl/imem_pkg.sv
// imem_pkg: instruction-memory sizing, XLEN and loader state encoding shared with the memory and core top
package imem_pkg;
  localparam int XLEN = 32;
  localparam int DEFAULT_MEM_SIZE = 256;
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERROR} loader_state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into XLEN-bit words, flagging the 4th byte of each word
module byte_packer
  import imem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);
  logic [1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] byte_ext, byte_mask;
  logic [4:0] sh;
  always_comb begin
    sh = {cnt_q, 3'b000};
    byte_ext = {{(XLEN-8){1'b0}}, in_data};
    byte_mask = {{(XLEN-8){1'b0}}, 8'hff};
    word = (word_q & ~(byte_mask << sh)) | (byte_ext << sh);
    word_valid = in_valid && !clr && cnt_q == 2'd3;
    cnt_d = clr ? 2'd0 : cnt_q + {1'b0, in_valid};
    word_d = clr ? '0 : in_valid ? word : word_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length/data/checksum byte frame into instruction-memory writes, holding the core until a good frame lands
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            load_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            err
);
  localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE);
  loader_state_e state_q, state_d;
  logic [15:0] len_q, len_d, idx_q, idx_d, n;
  logic [7:0] xor_q, xor_d;
  logic mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic accept, pk_valid, pk_clr, word_valid;
  logic [XLEN-1:0] word;
  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_data    (s_data),
    .word_valid (word_valid),
    .word       (word)
  );
  always_comb begin
    s_ready = state_q inside {LEN0, LEN1, DATA, CSUM};
    accept = s_valid && s_ready;
    n = {s_data, len_q[7:0]};
    pk_valid = accept && state_q == DATA;
    pk_clr = 1'b0;
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    xor_d = xor_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      LEN0: if (accept) begin
        len_d = {8'd0, s_data};
        state_d = LEN1;
      end
      LEN1: if (accept) begin
        len_d = n;
        state_d = n > MAX_LEN ? ERROR : n == 16'd0 ? CSUM : DATA;
      end
      DATA: begin
        if (accept) xor_d = xor_q ^ s_data;
        if (word_valid) begin
          mem_we_d = 1'b1;
          mem_addr_d = {{(XLEN-18){1'b0}}, idx_q, 2'b00};
          mem_wdata_d = word;
          idx_d = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1) state_d = CSUM;
        end
      end
      CSUM: if (accept) state_d = s_data == xor_q ? DONE : ERROR;
      default: if (load_req) begin
        state_d = LEN0;
        idx_d = '0;
        xor_d = '0;
        pk_clr = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN0;
      len_q <= '0;
      idx_q <= '0;
      xor_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      xor_q <= xor_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done = state_q == DONE;
  assign err = state_q == ERROR;
  assign cpu_hold = state_q != DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random frames checked against a frame-level model of the loader
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, load_req = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic s_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr, mem_wdata;
  int total = 0, bad = 0;
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  bit exp_done;
  bq_t two_word;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .load_req  (load_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) if (mem_we === 1'b1) begin
    got_a.push_back(mem_addr);
    got_d.push_back(mem_wdata);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Frame-level reference: words written in order, success iff length fits and checksum matches
  task automatic model(input bq_t b);
    int n;
    logic [7:0] x;
    exp_a.delete();
    exp_d.delete();
    n = {16'd0, b[1], b[0]};
    exp_done = 1'b0;
    if (n <= 256) begin
      x = 8'd0;
      for (int w = 0; w < n; w++) begin
        exp_a.push_back(32'(w * 4));
        exp_d.push_back({b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]});
        for (int k = 0; k < 4; k++) x ^= b[2+4*w+k];
      end
      exp_done = (b[2+4*n] == x);
    end
  endtask

  task automatic send(input bq_t b, input int gap, input bit noise);
    int t;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = b[i];
      load_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      t = 0;
      while (s_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t == 20) begin
        total++;
        bad++;
        $display("FAIL send_timeout byte=%0d s_ready=%b required=1", i, s_ready);
        s_valid = 1'b0;
        load_req = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      load_req = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic test_frame(input string name, input bq_t b, input int gap, input bit noise);
    logic [1:0] flags;
    got_a.delete();
    got_d.delete();
    model(b);
    send(b, gap, noise);
    total++;
    if ({done, err, cpu_hold} !== {exp_done, !exp_done, !exp_done}) begin
      bad++;
      $display("FAIL %s flags done/err/hold got=%b%b%b required=%b%b%b", name, done, err, cpu_hold,
               exp_done, !exp_done, !exp_done);
    end
    flags = {done, err};
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({s_ready, done, err} !== {1'b0, flags}) begin
        bad++;
        $display("FAIL %s idle_hold s_ready/done/err got=%b%b%b required=0%b", name, s_ready, done, err, flags);
      end
    end
    s_valid = 1'b0;
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++;
      $display("FAIL %s write_count got=%0d required=%0d", name, got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL %s write%0d got=%h<-%h required=%h<-%h", name, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    total++;
    if ({cpu_hold, s_ready, done, err} !== 4'b1100) begin
      bad++;
      $display("FAIL %s restart hold/ready/done/err got=%b%b%b%b required=1100", name, cpu_hold, s_ready, done, err);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== {1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values we=%b addr=%h wdata=%h hold=%b done=%b err=%b", mem_we, mem_addr, mem_wdata,
               cpu_hold, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b required=1", s_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    bq_t part;
    part = two_word[0:5];
    send(part, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== {1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_after_write we=%b addr=%h wdata=%h hold=%b", mem_we, mem_addr, mem_wdata, cpu_hold);
    end
    @(negedge clk);
    rst_n = 1'b1;
    part = two_word[0:4];
    send(part, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== {1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_word we=%b addr=%h wdata=%h hold=%b", mem_we, mem_addr, mem_wdata, cpu_hold);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_ready got=%b required=1", s_ready);
    end
    test_frame("after_reset", two_word, 0, 1'b0);
  endtask

  task automatic test_max_len();
    bq_t b;
    logic [7:0] x, d;
    b = {8'h00, 8'h01};
    x = 8'd0;
    for (int i = 0; i < 1024; i++) begin
      d = 8'($urandom);
      b.push_back(d);
      x ^= d;
    end
    b.push_back(x);
    test_frame("max_len", b, 0, 1'b0);
  endtask

  task automatic test_random();
    bq_t b;
    int n;
    logic [7:0] x, d;
    for (int f = 0; f < 30; f++) begin
      b.delete();
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(257, 65535);
        b = {n[7:0], n[15:8]};
      end else begin
        n = $urandom_range(0, 6);
        b = {n[7:0], n[15:8]};
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
          d = 8'($urandom);
          b.push_back(d);
          x ^= d;
        end
        b.push_back($urandom_range(0, 3) == 0 ? x ^ 8'($urandom_range(1, 255)) : x);
      end
      test_frame("random", b, $urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    two_word = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    test_reset();
    test_frame("two_word", two_word, 0, 1'b0);
    if (exp_a.size() != 2 || exp_d[0] != 32'h00500093 || exp_d[1] != 32'h00108133 || !exp_done) begin
      total++;
      bad++;
      $display("FAIL model_selfcheck words=%0d done=%b", exp_a.size(), exp_done);
    end
    test_frame("bad_csum", {two_word[0:9], 8'h62}, 0, 1'b0);
    test_frame("oversize", {8'h01, 8'h01}, 0, 1'b0);
    test_frame("zero_len", {8'h00, 8'h00, 8'h00}, 0, 1'b0);
    test_frame("throttle", two_word, 3, 1'b0);
    test_reset_mid_data();
    test_max_len();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
